// File: rtl/s2c_call_arb_if.sv
// Host call channel of s2c_call_arb: call issue towards the host and the host's response strobe.
// master = arbiter side, slave = host side.
interface s2c_call_arb_if #(
   parameter int FNW = 4,
   parameter int DW  = 32
);
   // Handshake: a call transfers on the rising edge where call_valid && call_ready.
   // Until then call_valid stays high and call_id/call_fn stay stable. resp_valid is
   // a single-cycle strobe with no back-pressure; resp_ret/resp_data are valid with it.
   logic           call_valid;
   logic           call_ready;
   logic [31:0]    call_id;
   logic [FNW-1:0] call_fn;
   logic           resp_valid;
   logic [31:0]    resp_ret;
   logic [DW-1:0]  resp_data;

   modport master (
      output call_valid, call_id, call_fn,
      input  call_ready, resp_valid, resp_ret, resp_data
   );

   modport slave (
      input  call_valid, call_id, call_fn,
      output call_ready, resp_valid, resp_ret, resp_data
   );
endinterface

// File: rtl/s2c_call_arb.sv
// Round-robin arbiter serialising N requesters' host calls onto one s2cif call channel.
// Optional response timeout enabled by defining S2C_ARB_TIMEOUT_EN.
module s2c_call_arb #(
   parameter int N           = 4,
   parameter int FNW         = 4,
   parameter int DW          = 32,
   parameter int BASE_ID     = 0,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N*FNW-1:0]   req_fn,
   output logic [N-1:0]       done,
   output logic [31:0]        rsp_ret,
   output logic [DW-1:0]      rsp_data,
   output logic [N-1:0]       ended,
   output logic               busy,
   output logic [1:0]         dbg_state,
   s2c_call_arb_if.master     host
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   logic [IW-1:0]  rr;
   logic [IW-1:0]  sel;
   logic [IW-1:0]  pick;
   logic           pick_valid;
   logic [FNW-1:0] pick_fn;
   logic [N-1:0]   elig;

   assign dbg_state = state;

   // Ended requesters are masked out permanently (until reset).
   assign elig = req & ~ended;

   // First eligible index at or after ptr, wrapping; scanned downwards so the
   // smallest offset is the last one written.
   function automatic logic [IW:0] first_eligible(input logic [N-1:0] e,
                                                  input logic [IW-1:0] ptr);
      logic [IW:0] res;
      int          j;
      res = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (e[IW'(j)]) res = {1'b1, IW'(j)};
      end
      return res;
   endfunction

   assign {pick_valid, pick} = first_eligible(elig, rr);

   always_comb begin
      pick_fn = '0;
      for (int k = 0; k < N; k++) begin
         if (pick == IW'(k)) pick_fn = req_fn[k*FNW +: FNW];
      end
   end

`ifdef S2C_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] wait_cnt;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         rr              <= '0;
         sel             <= '0;
         done            <= '0;
         rsp_ret         <= '0;
         rsp_data        <= '0;
         ended           <= '0;
         busy            <= 1'b0;
         host.call_valid <= 1'b0;
         host.call_id    <= '0;
         host.call_fn    <= '0;
`ifdef S2C_ARB_TIMEOUT_EN
         wait_cnt        <= '0;
`endif
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  sel             <= pick;
                  host.call_id    <= 32'(BASE_ID) + 32'(pick);
                  host.call_fn    <= pick_fn;
                  host.call_valid <= 1'b1;
                  busy            <= 1'b1;
                  rr              <= (pick == IW'(N - 1)) ? '0 : pick + IW'(1);
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               if (host.call_ready) begin
                  host.call_valid <= 1'b0;
                  state           <= WAIT;
`ifdef S2C_ARB_TIMEOUT_EN
                  wait_cnt        <= '0;
`endif
               end
            end
            WAIT: begin
               if (host.resp_valid) begin
                  rsp_ret   <= host.resp_ret;
                  rsp_data  <= host.resp_data;
                  done[sel] <= 1'b1;
                  if (host.resp_ret == 32'd1) ended[sel] <= 1'b1;
                  state     <= DONE;
`ifdef S2C_ARB_TIMEOUT_EN
               end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  // The TIMEOUT_CYC-th WAIT cycle without a response completes the call with ret=2.
                  rsp_ret   <= 32'd2;
                  rsp_data  <= '0;
                  done[sel] <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt  <= wait_cnt + CW'(1);
`endif
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done));

   a_busy_state: assert property (@(posedge clk) disable iff (rst) busy == (state != IDLE));

   a_call_hold: assert property (@(posedge clk) disable iff (rst)
      host.call_valid && !host.call_ready |=>
         host.call_valid && $stable(host.call_id) && $stable(host.call_fn));

endmodule

// File: tb/tb_s2c_call_arb.sv
// Self-checking bench for s2c_call_arb: directed table, hand sequences and a randomized run
// against a rotating-ring reference model.
module tb_s2c_call_arb;
   localparam int N       = 4;
   localparam int FNW     = 4;
   localparam int DW      = 32;
   localparam int BASE_ID = 5;
   localparam int TOC     = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N*FNW-1:0] req_fn;
   logic [N-1:0]     done;
   logic [31:0]      rsp_ret;
   logic [DW-1:0]    rsp_data;
   logic [N-1:0]     ended;
   logic             busy;
   logic [1:0]       dbg_state;

   s2c_call_arb_if #(.FNW(FNW), .DW(DW)) host_if ();

   s2c_call_arb #(.N(N), .FNW(FNW), .DW(DW), .BASE_ID(BASE_ID), .TIMEOUT_CYC(TOC)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_fn    (req_fn),
      .done      (done),
      .rsp_ret   (rsp_ret),
      .rsp_data  (rsp_data),
      .ended     (ended),
      .busy      (busy),
      .dbg_state (dbg_state),
      .host      (host_if)
   );

   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_bad = 0;
   logic [N-1:0] m_ended;
   int           ring[$];

   typedef struct {
      logic [N-1:0]     req;
      logic [N*FNW-1:0] fn;
      int               rdly;
      int               sdly;
      logic [31:0]      ret;
      logic [DW-1:0]    data;
      int               exp_k;
      logic [N-1:0]     exp_ended;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: requesters sit in a ring; the first eligible one in ring order is granted
   // and the ring is rotated so its successor becomes the head.
   task automatic model_reset();
      m_ended = '0;
      ring.delete();
      for (int i = 0; i < N; i++) ring.push_back(i);
   endtask

   task automatic model_grant(input logic [N-1:0] r, output int k);
      int p;
      p = -1;
      k = -1;
      for (int i = 0; i < N; i++) begin
         if (p < 0 && ((r >> ring[i]) & 1) != 0 && ((m_ended >> ring[i]) & 1) == 0) p = i;
      end
      if (p >= 0) begin
         k = ring[p];
         for (int i = 0; i <= p; i++) ring.push_back(ring.pop_front());
      end
   endtask

   task automatic reset_dut();
      req = '0;
      host_if.call_ready = 1'b0;
      host_if.resp_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
   endtask

   // Entered at an IDLE negedge with req/req_fn already driven; leaves at the next IDLE negedge.
   task automatic do_call(input int k, input logic [N*FNW-1:0] fnw, input int rdly, input int sdly,
                          input logic [31:0] ret, input logic [DW-1:0] data,
                          input logic [N-1:0] exp_ended);
      logic [FNW-1:0] efn;
      logic [N-1:0]   eone;
      efn  = FNW'(fnw >> (FNW * k));
      eone = N'(1) << k;
      @(negedge clk);
      check("issue_valid", 64'(host_if.call_valid), 64'd1);
      check("issue_busy", 64'(busy), 64'd1);
      check("issue_id", 64'(host_if.call_id), 64'(BASE_ID + k));
      check("issue_fn", 64'(host_if.call_fn), 64'(efn));
      for (int i = 0; i < rdly; i++) begin
         host_if.call_ready = 1'b0;
         host_if.resp_valid = 1'b1;
         host_if.resp_ret   = 32'd1;
         @(negedge clk);
         check("hold_valid", 64'(host_if.call_valid), 64'd1);
         check("hold_id", 64'(host_if.call_id), 64'(BASE_ID + k));
         check("hold_fn", 64'(host_if.call_fn), 64'(efn));
         check("hold_done", 64'(done), 64'd0);
      end
      host_if.call_ready = 1'b1;
      host_if.resp_valid = 1'b0;
      @(negedge clk);
      host_if.call_ready = 1'b0;
      check("wait_valid", 64'(host_if.call_valid), 64'd0);
      check("wait_busy", 64'(busy), 64'd1);
      for (int i = 0; i < sdly; i++) begin
         @(negedge clk);
         check("wait_done", 64'(done), 64'd0);
      end
      host_if.resp_valid = 1'b1;
      host_if.resp_ret   = ret;
      host_if.resp_data  = data;
      @(negedge clk);
      host_if.resp_valid = 1'b0;
      check("done_pulse", 64'(done), 64'(eone));
      check("done_ret", 64'(rsp_ret), 64'(ret));
      check("done_data", 64'(rsp_data), 64'(data));
      check("done_ended", 64'(ended), 64'(exp_ended));
      req = req & ~eone;
      @(negedge clk);
      check("idle_done", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_hold_data", 64'(rsp_data), 64'(data));
   endtask

   task automatic no_grant();
      @(negedge clk);
      check("nogrant_busy", 64'(busy), 64'd0);
      check("nogrant_valid", 64'(host_if.call_valid), 64'd0);
      req = '0;
   endtask

   logic [1:0] exp_q[$];
   logic [1:0] got_q[$];
   int         got_cyc[$];

   initial begin
      req = '0;
      req_fn = '0;
      host_if.call_ready = 1'b0;
      host_if.resp_valid = 1'b0;
      host_if.resp_ret   = '0;
      host_if.resp_data  = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ret", 64'(rsp_ret), 64'd0);
      check("rst_data", 64'(rsp_data), 64'd0);
      check("rst_ended", 64'(ended), 64'd0);
      check("rst_valid", 64'(host_if.call_valid), 64'd0);
      check("rst_id", 64'(host_if.call_id), 64'd0);
      check("rst_fn", 64'(host_if.call_fn), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      model_reset();

      // Directed table, starting from pointer 0 with nothing ended.
      tbl[0] = '{4'b0100, 16'h0000, 0, 0, 32'd0, 32'h0000_0001, 2, 4'b0000};
      tbl[1] = '{4'b1111, 16'h4321, 5, 0, 32'd0, 32'h0000_A5A5, 3, 4'b0000};
      tbl[2] = '{4'b0010, 16'h00B0, 0, 2, 32'd1, 32'h0000_0000, 1, 4'b0010};
      tbl[3] = '{4'b1010, 16'h7000, 0, 0, 32'd0, 32'h0000_0033, 3, 4'b0010};
      tbl[4] = '{4'b1010, 16'h5A00, 1, 1, 32'd0, 32'h0000_0044, 3, 4'b0010};
      tbl[5] = '{4'b0010, 16'h00F0, 0, 0, 32'd0, 32'h0000_0000, -1, 4'b0010};
      tbl[6] = '{4'b0001, 16'h000C, 0, 0, 32'd3, 32'hDEAD_BEEF, 0, 4'b0010};
      tbl[7] = '{4'b0110, 16'h0D90, 2, 3, 32'd1, 32'h1234_5678, 2, 4'b0110};
      for (int i = 0; i < 8; i++) begin
         req    = tbl[i].req;
         req_fn = tbl[i].fn;
         if (tbl[i].exp_k < 0) no_grant();
         else do_call(tbl[i].exp_k, tbl[i].fn, tbl[i].rdly, tbl[i].sdly, tbl[i].ret,
                      tbl[i].data, tbl[i].exp_ended);
      end

      // Fairness: all requesting continuously with an always-ready host.
      reset_dut();
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      req = 4'b1111;
      req_fn = 16'h4321;
      host_if.call_ready = 1'b1;
      host_if.resp_valid = 1'b1;
      host_if.resp_ret   = 32'd0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done != '0) begin
            for (int b = 0; b < N; b++) if (done == (N'(1) << b)) got_q.push_back(2'(b));
            if (!$onehot(done)) got_q.push_back(2'd0);
            got_cyc.push_back(c);
         end
      end
      req = '0;
      host_if.call_ready = 1'b0;
      host_if.resp_valid = 1'b0;
      check("rr_count", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check("rr_order", 64'(got_q[i]), 64'(exp_q[i]));
         if (i > 0 && i < got_cyc.size()) check("rr_spacing", 64'(got_cyc[i] - got_cyc[i-1]), 64'd4);
      end
      if (got_cyc.size() > 0) check("rr_first_done", 64'(got_cyc[0]), 64'd2);
      repeat (2) @(negedge clk);

      // Reset pulse while waiting for a response; a late response must be ignored.
      reset_dut();
      req = 4'b0001;
      req_fn = 16'h0006;
      host_if.call_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      host_if.call_ready = 1'b0;
      check("rstw_in_wait", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("rstw_busy", 64'(busy), 64'd0);
      check("rstw_state", 64'(dbg_state), 64'd0);
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      host_if.resp_valid = 1'b1;
      host_if.resp_ret   = 32'd1;
      host_if.resp_data  = 32'hBAD0_BAD0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("late_done", 64'(done), 64'd0);
         check("late_ended", 64'(ended), 64'd0);
         check("late_data", 64'(rsp_data), 64'd0);
         check("late_busy", 64'(busy), 64'd0);
      end
      host_if.resp_valid = 1'b0;

      // Randomized calls against the ring model.
      reset_dut();
      for (int it = 0; it < 60; it++) begin
         logic [N-1:0]     r;
         logic [N*FNW-1:0] f;
         logic [31:0]      rt;
         logic [DW-1:0]    d;
         int               k;
         if (m_ended == '1) reset_dut();
         r  = N'($urandom_range(1, (1 << N) - 1));
         f  = (N*FNW)'($urandom);
         rt = ($urandom_range(0, 7) == 0) ? 32'd1 : ($urandom_range(0, 1) == 1 ? 32'd0 : $urandom);
         d  = DW'($urandom);
         req    = r;
         req_fn = f;
         model_grant(r, k);
         if (k < 0) no_grant();
         else begin
            if (rt == 32'd1) m_ended = m_ended | (N'(1) << k);
            do_call(k, f, $urandom_range(0, 3), $urandom_range(0, 3), rt, d, m_ended);
         end
      end

`ifdef S2C_ARB_TIMEOUT_EN
      reset_dut();
      req = 4'b0010;
      req_fn = 16'h0050;
      do_call(1, 16'h0050, 0, 0, 32'd0, 32'h0000_CAFE, 4'b0000);
      req = 4'b0001;
      req_fn = 16'h0009;
      host_if.call_ready = 1'b1;
      @(negedge clk);
      check("to_issue", 64'(host_if.call_valid), 64'd1);
      @(negedge clk);
      host_if.call_ready = 1'b0;
      for (int i = 1; i < TOC; i++) begin
         @(negedge clk);
         check("to_wait_done", 64'(done), 64'd0);
      end
      @(negedge clk);
      check("to_done", 64'(done), 64'b0001);
      check("to_ret", 64'(rsp_ret), 64'd2);
      check("to_data", 64'(rsp_data), 64'd0);
      check("to_ended", 64'(ended), 64'd0);
      req = '0;
      @(negedge clk);
      req = 4'b0001;
      do_call(0, 16'h0009, 0, TOC - 1, 32'd7, 32'h0000_1234, 4'b0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
